// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache: zero-latency hits, one outstanding
// single-word fill per miss, whole-cache flush and saturating hit/miss counters.
module icache_direct #(
    parameter int SETS  = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             iflush,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic [31:0]      iload,
    input  logic             iwait,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [29:0]      miss_word_q, miss_word_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             lookup_hit, miss_take, fill_done;
    logic             unused_addr_lsb;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    assign req_idx         = imemaddr[IDX_W+1:2];
    assign req_tag         = imemaddr[31:IDX_W+2];
    assign fill_idx        = miss_word_q[IDX_W-1:0];
    assign fill_tag        = miss_word_q[29:IDX_W];
    assign unused_addr_lsb = ^imemaddr[1:0];

    // Lookup happens only in IDLE; a fill never bypasses straight to the datapath.
    assign lookup_hit = imemREN && (state_q == IDLE) && valid_q[req_idx]
                        && (tag_q[req_idx] == req_tag);
    assign miss_take  = imemREN && (state_q == IDLE) && !lookup_hit;
    assign fill_done  = (state_q == FETCH) && !iwait;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_take) state_d = FETCH;
            FETCH:   if (!iwait)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        case (state_q)
            IDLE: begin
                ihit     = lookup_hit;
                imemload = lookup_hit ? data_q[req_idx] : '0;
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_word_q, 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        miss_word_d = miss_word_q;
        if (miss_take) miss_word_d = imemaddr[31:2];
        if (fill_done) valid_d[fill_idx] = 1'b1;
        // Flush wins over a fill retiring on the same edge.
        if (iflush) valid_d = '0;
        hit_count_d  = sat_inc(hit_count_q, lookup_hit);
        miss_count_d = sat_inc(miss_count_q, miss_take);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q      <= '0;
            miss_word_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            miss_word_q  <= miss_word_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios plus a randomized run, all checked against a
// frame-level model that stores the full word address cached in each frame.
module tb_icache_direct;
    localparam int SETS  = 16;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             CLK = 1'b0;
    logic             RST, imemREN, iflush, iwait;
    logic [31:0]      imemaddr, iload;
    logic             ihit, iREN;
    logic [31:0]      imemload, iaddr;
    logic [CNT_W-1:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_bad = 0;

    bit               m_fetch;
    logic [31:0]      m_miss_word;
    bit               m_valid [SETS];
    logic [31:0]      m_word  [SETS];
    logic [CNT_W-1:0] m_hits, m_misses;

    logic        exp_ihit, exp_iren, obs_ihit, obs_iren;
    logic [31:0] exp_load, exp_iaddr, obs_load, obs_iaddr;

    icache_direct #(.SETS(SETS), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
        .imemload(imemload), .iflush(iflush), .iREN(iREN), .iaddr(iaddr), .iload(iload),
        .iwait(iwait), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    // Backing memory contents: a fixed word for 0x40, a hash of the address elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0000_0040) return 32'h2001_0005;
        return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        m_fetch = 0; m_miss_word = 0; m_hits = 0; m_misses = 0;
        for (int k = 0; k < SETS; k++) begin m_valid[k] = 0; m_word[k] = 0; end
    endtask

    task automatic model_predict();
        int unsigned idx;
        idx = (imemaddr >> 2) % SETS;
        exp_ihit  = imemREN && !m_fetch && m_valid[idx] && (m_word[idx] == (imemaddr >> 2));
        exp_load  = exp_ihit ? mem_word(imemaddr) : 32'h0;
        exp_iren  = m_fetch;
        exp_iaddr = m_fetch ? (m_miss_word << 2) : 32'h0;
    endtask

    task automatic model_edge();
        int unsigned idx;
        if (exp_ihit && m_hits != CNT_MAX) m_hits++;
        if (!m_fetch) begin
            if (imemREN && !exp_ihit) begin
                m_fetch = 1; m_miss_word = imemaddr >> 2;
                if (m_misses != CNT_MAX) m_misses++;
            end
        end else if (!iwait) begin
            idx = m_miss_word % SETS;
            m_valid[idx] = 1; m_word[idx] = m_miss_word; m_fetch = 0;
        end
        if (iflush) for (int k = 0; k < SETS; k++) m_valid[k] = 0;
    endtask

    // One clock: drive at posedge+1, sample at posedge+4, advance the model at the edge.
    task automatic cyc(input logic ren, input logic [31:0] addr, input logic fl, input logic wt);
        imemREN = ren; imemaddr = addr; iflush = fl; iwait = wt;
        model_predict();
        iload = wt ? $urandom : mem_word(m_miss_word << 2);
        #3;
        obs_ihit = ihit; obs_load = imemload; obs_iren = iREN; obs_iaddr = iaddr;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic miss_fill(input logic [31:0] addr, input int waits);
        cyc(1, addr, 0, 1);
        repeat (waits) cyc(1, addr, 0, 1);
        cyc(1, addr, 0, 0);
    endtask

    task automatic test_reset();
        RST = 1; imemREN = 0; imemaddr = 0; iflush = 0; iwait = 1; iload = 0;
        model_reset();
        #2;
        n_cmp++; if (ihit !== 1'b0)       begin n_bad++; $display("FAIL reset_ihit got %b want 0", ihit); end
        n_cmp++; if (imemload !== 32'h0)  begin n_bad++; $display("FAIL reset_imemload got %h want 0", imemload); end
        n_cmp++; if (iREN !== 1'b0)       begin n_bad++; $display("FAIL reset_iREN got %b want 0", iREN); end
        n_cmp++; if (iaddr !== 32'h0)     begin n_bad++; $display("FAIL reset_iaddr got %h want 0", iaddr); end
        n_cmp++; if (hit_count !== '0)    begin n_bad++; $display("FAIL reset_hit_count got %0d want 0", hit_count); end
        n_cmp++; if (miss_count !== '0)   begin n_bad++; $display("FAIL reset_miss_count got %0d want 0", miss_count); end
        @(posedge CLK); #1;
        RST = 0;
    endtask

    task automatic test_cold_miss();
        int iren_cycles = 0;
        int hit_cyc = 0;
        for (int c = 1; c <= 6; c++) begin
            cyc(1, 32'h40, 0, (c == 5) ? 1'b0 : 1'b1);
            n_cmp++; if (obs_ihit !== exp_ihit) begin n_bad++; $display("FAIL cold_ihit c%0d got %b want %b", c, obs_ihit, exp_ihit); end
            if (obs_iren === 1'b1) begin
                iren_cycles++;
                n_cmp++; if (obs_iaddr !== 32'h40) begin n_bad++; $display("FAIL cold_iaddr c%0d got %h want 00000040", c, obs_iaddr); end
            end
            if (obs_ihit === 1'b1 && hit_cyc == 0) hit_cyc = c;
        end
        n_cmp++; if (iren_cycles != 4) begin n_bad++; $display("FAIL cold_iren_cycles got %0d want 4", iren_cycles); end
        n_cmp++; if (hit_cyc != 6) begin n_bad++; $display("FAIL cold_hit_cycle got %0d want 6", hit_cyc); end
        n_cmp++; if (obs_load !== 32'h2001_0005) begin n_bad++; $display("FAIL cold_load got %h want 20010005", obs_load); end
        n_cmp++; if (miss_count !== 5'd1) begin n_bad++; $display("FAIL cold_miss_count got %0d want 1", miss_count); end
    endtask

    task automatic test_repeat_hit();
        for (int c = 0; c < 4; c++) begin
            cyc(1, 32'h40, 0, 1);
            n_cmp++; if (obs_ihit !== 1'b1) begin n_bad++; $display("FAIL rep_ihit c%0d got %b want 1", c, obs_ihit); end
            n_cmp++; if (obs_iren !== 1'b0) begin n_bad++; $display("FAIL rep_iREN c%0d got %b want 0", c, obs_iren); end
            n_cmp++; if (obs_load !== 32'h2001_0005) begin n_bad++; $display("FAIL rep_load c%0d got %h want 20010005", c, obs_load); end
        end
        n_cmp++; if (hit_count !== 5'd5) begin n_bad++; $display("FAIL rep_hit_count got %0d want 5", hit_count); end
    endtask

    task automatic test_conflict();
        logic [CNT_W-1:0] base;
        base = m_misses;
        miss_fill(32'h0, 0);
        miss_fill(32'h40, 0);
        cyc(1, 32'h0, 0, 1);
        n_cmp++; if (obs_ihit !== 1'b0) begin n_bad++; $display("FAIL conf_ihit got %b want 0", obs_ihit); end
        cyc(1, 32'h0, 0, 1);
        n_cmp++; if (obs_iren !== 1'b1 || obs_iaddr !== 32'h0) begin n_bad++; $display("FAIL conf_req got iREN=%b iaddr=%h want 1/00000000", obs_iren, obs_iaddr); end
        n_cmp++; if (miss_count !== base + 5'd3) begin n_bad++; $display("FAIL conf_miss_count got %0d want %0d", miss_count, base + 5'd3); end
        cyc(1, 32'h0, 0, 0);
    endtask

    task automatic test_redirect();
        cyc(1, 32'h80, 0, 1);
        for (int c = 0; c < 3; c++) begin
            cyc(1, 32'h100, 0, (c == 2) ? 1'b0 : 1'b1);
            n_cmp++; if (obs_iren !== 1'b1 || obs_iaddr !== 32'h80) begin n_bad++; $display("FAIL redir_old c%0d got iREN=%b iaddr=%h want 1/00000080", c, obs_iren, obs_iaddr); end
        end
        cyc(1, 32'h100, 0, 1);
        n_cmp++; if (obs_ihit !== 1'b0 || obs_iren !== 1'b0) begin n_bad++; $display("FAIL redir_lookup got ihit=%b iREN=%b want 0/0", obs_ihit, obs_iren); end
        cyc(1, 32'h100, 0, 0);
        n_cmp++; if (obs_iren !== 1'b1 || obs_iaddr !== 32'h100) begin n_bad++; $display("FAIL redir_new got iREN=%b iaddr=%h want 1/00000100", obs_iren, obs_iaddr); end
        cyc(1, 32'h100, 0, 1);
        n_cmp++; if (obs_ihit !== 1'b1 || obs_load !== mem_word(32'h100)) begin n_bad++; $display("FAIL redir_hit got ihit=%b load=%h want 1/%h", obs_ihit, obs_load, mem_word(32'h100)); end
        cyc(1, 32'h80, 0, 1);
        n_cmp++; if (obs_ihit !== exp_ihit) begin n_bad++; $display("FAIL redir_old_frame got %b want %b", obs_ihit, exp_ihit); end
        cyc(1, 32'h80, 0, 0);
    endtask

    task automatic test_flush_fill();
        cyc(1, 32'h44, 0, 1);
        cyc(1, 32'h44, 1, 0);
        cyc(1, 32'h44, 0, 1);
        n_cmp++; if (obs_ihit !== 1'b0) begin n_bad++; $display("FAIL flush_fill_ihit got %b want 0", obs_ihit); end
        cyc(1, 32'h44, 0, 0);
        cyc(1, 32'h44, 0, 1);
        n_cmp++; if (obs_ihit !== 1'b1 || obs_load !== mem_word(32'h44)) begin n_bad++; $display("FAIL flush_refill got ihit=%b load=%h want 1/%h", obs_ihit, obs_load, mem_word(32'h44)); end
        cyc(1, 32'h80, 0, 1);
        n_cmp++; if (obs_ihit !== 1'b0) begin n_bad++; $display("FAIL flush_other_frame got %b want 0", obs_ihit); end
        cyc(1, 32'h80, 0, 0);
    endtask

    task automatic test_reset_mid_fetch();
        miss_fill(32'h40, 0);
        cyc(1, 32'h40, 0, 1);
        n_cmp++; if (obs_ihit !== 1'b1) begin n_bad++; $display("FAIL rmf_prefill got %b want 1", obs_ihit); end
        cyc(1, 32'h204, 0, 1);
        iwait = 0; iload = 32'hDEAD_BEEF; RST = 1;
        #1;
        n_cmp++; if (iREN !== 1'b0) begin n_bad++; $display("FAIL rmf_iREN got %b want 0", iREN); end
        n_cmp++; if (hit_count !== '0 || miss_count !== '0) begin n_bad++; $display("FAIL rmf_counters got %0d/%0d want 0/0", hit_count, miss_count); end
        model_reset();
        @(posedge CLK); #1;
        RST = 0;
        cyc(1, 32'h40, 0, 1);
        n_cmp++; if (obs_ihit !== 1'b0) begin n_bad++; $display("FAIL rmf_after_ihit got %b want 0", obs_ihit); end
        cyc(1, 32'h40, 0, 0);
        n_cmp++; if (obs_iren !== 1'b1 || obs_iaddr !== 32'h40) begin n_bad++; $display("FAIL rmf_after_req got iREN=%b iaddr=%h want 1/00000040", obs_iren, obs_iaddr); end
        n_cmp++; if (miss_count !== 5'd1) begin n_bad++; $display("FAIL rmf_miss_count got %0d want 1", miss_count); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic ren, fl, wt;
        a = 32'h0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0)
                a = ({$urandom_range(0, 39)} << 2) | (($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'h0)
                    | {$urandom_range(0, 3)};
            ren = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 29) == 0);
            wt  = $urandom_range(0, 1);
            cyc(ren, a, fl, wt);
            n_cmp++; if (obs_ihit !== exp_ihit)   begin n_bad++; $display("FAIL rnd_ihit i%0d got %b want %b", i, obs_ihit, exp_ihit); end
            n_cmp++; if (obs_load !== exp_load)   begin n_bad++; $display("FAIL rnd_load i%0d got %h want %h", i, obs_load, exp_load); end
            n_cmp++; if (obs_iren !== exp_iren)   begin n_bad++; $display("FAIL rnd_iREN i%0d got %b want %b", i, obs_iren, exp_iren); end
            n_cmp++; if (obs_iaddr !== exp_iaddr) begin n_bad++; $display("FAIL rnd_iaddr i%0d got %h want %h", i, obs_iaddr, exp_iaddr); end
        end
        n_cmp++; if (hit_count !== m_hits)    begin n_bad++; $display("FAIL rnd_hit_count got %0d want %0d", hit_count, m_hits); end
        n_cmp++; if (miss_count !== m_misses) begin n_bad++; $display("FAIL rnd_miss_count got %0d want %0d", miss_count, m_misses); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_repeat_hit();
        test_conflict();
        test_redirect();
        test_flush_fill();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
